// File: rtl/ev_hash_sequencer_pkg.sv
// Shared error-verification hasher constants and sequencer state type.
// Imported by the sequencer interface and RTL.
package ev_hash_sequencer_pkg;
  localparam int EV_W             = 64;
  localparam int EV_K             = 64;
  localparam int EV_HASHTAG_WIDTH = 64;
  // Random words needed to fill the hasher's two shift stages before hashing
  localparam int EV_PRELOAD_WORDS = (EV_K + EV_W) / EV_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_HASH,
    S_CAPTURE
  } seq_state_e;
endpackage

// File: rtl/ev_hash_sequencer_if.sv
// Random-word and reconciled-key valid/ready streams feeding the hash sequencer.
// master = upstream word sources, slave = sequencer.
interface ev_hash_sequencer_if;
  import ev_hash_sequencer_pkg::*;

  logic [EV_W-1:0] rnd_data;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [EV_W-1:0] key_data;
  logic            key_valid;
  logic            key_ready;

  modport master (
    output rnd_data, rnd_valid, key_data, key_valid,
    input  rnd_ready, key_ready
  );

  modport slave (
    input  rnd_data, rnd_valid, key_data, key_valid,
    output rnd_ready, key_ready
  );
endinterface

// File: rtl/ev_hash_sequencer.sv
// Feeds the Toeplitz hasher from the random/key streams for one run of N key words,
// then captures the final tag for its single valid cycle and compares it with the peer tag.
module ev_hash_sequencer
  import ev_hash_sequencer_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    key_len_words,
  ev_hash_sequencer_if.slave  strm,
  output logic [EV_W-1:0]     hs_random_bit,
  output logic                hs_shift_en,
  output logic [EV_W-1:0]     hs_key_bit,
  output logic                hs_key_en,
  input  logic [EV_K-1:0]     hs_hash_tag,
  input  logic [EV_K-1:0]     peer_tag,
  output logic                busy,
  output logic [EV_K-1:0]     tag_out,
  output logic                tag_valid,
  output logic                match,
  output logic                len_err
);

  seq_state_e       state, state_nxt;
  logic [1:0]       pre_cnt;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] n_len;
  logic             last;
  logic             kfire;
  logic             accept;
  logic             zero_req;
  logic             rnd_rdy;
  logic             key_rdy;

  assign last     = (idx == n_len - 1'b1);
  assign accept   = (state == S_IDLE) && start && !abort && (key_len_words != '0);
  assign zero_req = (state == S_IDLE) && start && !abort && (key_len_words == '0);
  assign busy     = (state != S_IDLE);

  assign strm.rnd_ready = rnd_rdy;
  assign strm.key_ready = key_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rnd_rdy       = 1'b0;
    key_rdy       = 1'b0;
    hs_shift_en   = 1'b0;
    hs_key_en     = 1'b0;
    hs_random_bit = '0;
    hs_key_bit    = '0;
    kfire         = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_PRELOAD;
      end
      S_PRELOAD: begin
        hs_random_bit = strm.rnd_data;
        if (!abort) begin
          rnd_rdy     = 1'b1;
          hs_shift_en = strm.rnd_valid;
          if (strm.rnd_valid && (pre_cnt == 2'(EV_PRELOAD_WORDS - 1))) state_nxt = S_HASH;
        end
      end
      S_HASH: begin
        hs_random_bit = strm.rnd_data;
        if (!abort) begin
          // key_en stays up through stalls; a zeroed key word leaves the MAC sums intact
          hs_key_en   = 1'b1;
          kfire       = strm.key_valid && (last || strm.rnd_valid);
          key_rdy     = kfire;
          rnd_rdy     = kfire && !last;
          hs_shift_en = kfire && !last;
          hs_key_bit  = kfire ? strm.key_data : '0;
          if (kfire && last) state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      idx       <= '0;
      n_len     <= '0;
      tag_out   <= '0;
      tag_valid <= 1'b0;
      match     <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      tag_valid <= 1'b0;
      len_err   <= zero_req;
      if (accept) begin
        n_len   <= key_len_words;
        pre_cnt <= '0;
        idx     <= '0;
      end
      if (state == S_PRELOAD && hs_shift_en) pre_cnt <= pre_cnt + 2'd1;
      if (kfire) idx <= idx + 1'b1;
      // The hasher clears its tag on this edge, so this is the only chance to grab it
      if (state == S_CAPTURE && !abort) begin
        tag_out   <= hs_hash_tag;
        match     <= (hs_hash_tag == peer_tag);
        tag_valid <= 1'b1;
      end
    end
  end

endmodule
